int_to_fp_converter: RTL and testbench

Multi-cycle integer-to-single-precision converter for the FPU. It implements FCVT.S.W (signed) and FCVT.S.WU (unsigned) for the CPU core, the reverse direction of the existing float-to-integer path. Conversion uses a start/valid handshake with fixed latency, a 5-stage iterative normalizer and full RISC-V rounding-mode support. It sits beside the combinational FPU. The core's pipeline stalls on BUSY and takes RESULT on VALID.

---
 rtl/int_to_fp_converter_pkg.sv | 60 ++++++
 rtl/int_to_fp_converter_round.sv | 47 ++++
 rtl/int_to_fp_converter.sv | 99 +++++++++
 tb/tb_int_to_fp_converter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/int_to_fp_converter_pkg.sv
// Shared definitions for the integer-to-binary32 converter: rounding-mode
// codes, exponent bias, FSM encodings and the one-step normalizer helper.
package int_to_fp_converter_pkg;

  // RISC-V rounding-mode encodings; 101..111 are folded into RNE by the rounder.
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [7:0] FP_BIAS  = 8'd127;
  // Exponent of an unnormalized magnitude whose leading one sits at bit 31.
  localparam logic [7:0] EXP_INIT = FP_BIAS + 8'd31;

  // FSM encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] LAST_STAGE = 3'd4;

  typedef struct packed {
    logic [31:0] mag;
    logic [7:0]  exp;
  } norm_t;

  // One normalizer stage: stage k shifts by 16 >> k when the top (16 >> k)
  // bits are all zero. Five stages leave the leading one at bit 31.
  function automatic norm_t norm_step(input norm_t cur, input logic [2:0] stage);
    norm_t nxt;
    nxt = cur;
    case (stage)
      3'd0: if (cur.mag[31:16] == 16'h0) begin
        nxt.mag = {cur.mag[15:0], 16'h0};
        nxt.exp = cur.exp - 8'd16;
      end
      3'd1: if (cur.mag[31:24] == 8'h0) begin
        nxt.mag = {cur.mag[23:0], 8'h0};
        nxt.exp = cur.exp - 8'd8;
      end
      3'd2: if (cur.mag[31:28] == 4'h0) begin
        nxt.mag = {cur.mag[27:0], 4'h0};
        nxt.exp = cur.exp - 8'd4;
      end
      3'd3: if (cur.mag[31:30] == 2'h0) begin
        nxt.mag = {cur.mag[29:0], 2'h0};
        nxt.exp = cur.exp - 8'd2;
      end
      3'd4: if (cur.mag[31] == 1'b0) begin
        nxt.mag = {cur.mag[30:0], 1'b0};
        nxt.exp = cur.exp - 8'd1;
      end
      default: ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/int_to_fp_converter_round.sv
// Combinational rounding of a normalized 32-bit magnitude into binary32.
// Kept standalone so other conversion paths can reuse the mode decode.
module int_to_fp_round
  import int_to_fp_converter_pkg::*;
(
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [31:0] mag,
  input  logic [2:0]  mode,
  output logic [31:0] result,
  output logic        inexact
);

  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic [23:0] mant_sum;
  logic [7:0]  exp_r;
  logic        is_zero;

  assign mant    = mag[30:8];
  assign guard   = mag[7];
  assign sticky  = |mag[6:0];
  // After normalization bit 31 is clear only when the operand was zero.
  assign is_zero = ~mag[31];

  // Rounding-increment decode; unused mode codes behave as RNE.
  always_comb begin
    inc = 1'b0;
    case (mode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (guard | sticky);
      RM_RUP:  inc = ~sign & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mant[0]);
    endcase
  end

  // Mantissa carry-out bumps the exponent; the mantissa wraps to zero.
  assign mant_sum = {1'b0, mant} + {23'h0, inc};
  assign exp_r    = exp + {7'h0, mant_sum[23]};

  assign result  = is_zero ? 32'h0 : {sign, exp_r, mant_sum[22:0]};
  assign inexact = is_zero ? 1'b0 : (guard | sticky);

endmodule

// File: rtl/int_to_fp_converter.sv
// Iterative int32/uint32 to binary32 converter (FCVT.S.W / FCVT.S.WU).
// Handshake: START is accepted only in IDLE or DONE; BUSY is high in NORM and
// ROUND; VALID is a one-cycle pulse in DONE, and RESULT/INEXACT hold their
// value until the next VALID. Fixed latency of 7 cycles from START to VALID.
module int_to_fp_converter
  import int_to_fp_converter_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] DATA1,
  input  logic        UNSIGNED,
  input  logic [2:0]  ROUND_MODE,
  output logic        BUSY,
  output logic        VALID,
  output logic [31:0] RESULT,
  output logic        INEXACT,
  output logic [1:0]  dbg_state
);

  logic [1:0]  state_q;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;
  logic [2:0]  stage_q;
  logic        zero_q;
  logic [2:0]  mode_q;

  logic        accept;
  logic        in_sign;
  norm_t       norm_cur;
  norm_t       norm_nxt;
  logic [31:0] rnd_result;
  logic        rnd_inexact;

  assign accept  = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_sign = ~UNSIGNED & DATA1[31];

  // Normalizer datapath for the current stage.
  always_comb begin
    norm_cur.mag = mag_q;
    norm_cur.exp = exp_q;
    norm_nxt     = norm_step(norm_cur, stage_q);
  end

  int_to_fp_round u_round (
    .sign    (sign_q),
    .exp     (exp_q),
    .mag     (mag_q),
    .mode    (mode_q),
    .result  (rnd_result),
    .inexact (rnd_inexact)
  );

  // FSM, operand capture, normalizer iteration and result registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= 32'h0;
      exp_q   <= 8'h0;
      stage_q <= 3'h0;
      zero_q  <= 1'b0;
      mode_q  <= 3'h0;
      RESULT  <= 32'h0;
      INEXACT <= 1'b0;
    end else if (accept) begin
      state_q <= ST_NORM;
      sign_q  <= in_sign;
      mag_q   <= in_sign ? (~DATA1 + 32'd1) : DATA1;
      exp_q   <= EXP_INIT;
      stage_q <= 3'h0;
      zero_q  <= (DATA1 == 32'h0);
      mode_q  <= ROUND_MODE;
    end else begin
      case (state_q)
        ST_NORM: begin
          mag_q   <= norm_nxt.mag;
          exp_q   <= norm_nxt.exp;
          stage_q <= stage_q + 3'd1;
          if (stage_q == LAST_STAGE) state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          RESULT  <= zero_q ? 32'h0 : rnd_result;
          INEXACT <= zero_q ? 1'b0 : rnd_inexact;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Status outputs decode straight from the state register.
  assign BUSY      = (state_q == ST_NORM) || (state_q == ST_ROUND);
  assign VALID     = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Directed bench for int_to_fp_converter with hand-computed binary32 results.
module tb_int_to_fp_converter;

  localparam logic [2:0] M_RNE = 3'b000;
  localparam logic [2:0] M_RTZ = 3'b001;
  localparam logic [2:0] M_RDN = 3'b010;
  localparam logic [2:0] M_RUP = 3'b011;
  localparam logic [2:0] M_RMM = 3'b100;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [31:0] DATA1 = 32'h0;
  logic        UNSIGNED = 1'b0;
  logic [2:0]  ROUND_MODE = 3'h0;
  logic        BUSY;
  logic        VALID;
  logic [31:0] RESULT;
  logic        INEXACT;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  // Scoreboard entries: {inexact, result}.
  logic [32:0] exp_q[$];

  int_to_fp_converter dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .DATA1      (DATA1),
    .UNSIGNED   (UNSIGNED),
    .ROUND_MODE (ROUND_MODE),
    .BUSY       (BUSY),
    .VALID      (VALID),
    .RESULT     (RESULT),
    .INEXACT    (INEXACT),
    .dbg_state  (dbg_state)
  );

  // Clock.
  always #5 CLK = ~CLK;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Drive one START cycle; with hold set, START stays high afterwards.
  task automatic start_conv(input logic [31:0] data, input logic uns,
                            input logic [2:0] mode, input logic hold);
    @(negedge CLK);
    START = 1'b1;
    DATA1 = data;
    UNSIGNED = uns;
    ROUND_MODE = mode;
    @(negedge CLK);
    START = hold;
    DATA1 = $urandom;
    UNSIGNED = ~uns;
    ROUND_MODE = 3'($urandom_range(0, 7));
  endtask

  // Compare RESULT/INEXACT against the oldest scoreboard entry.
  task automatic check_result(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s observed=unexpected_valid expected=empty_scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, RESULT, e[31:0]);
      check({tag, "_inexact"}, {31'h0, INEXACT}, {31'h0, e[32]});
    end
  endtask

  // Called in cycle 1: BUSY in cycles 1..6, VALID in cycle 7 (returns in cycle 7).
  task automatic expect_window(input string tag);
    for (int c = 1; c <= 6; c++) begin
      check({tag, "_busy"}, {31'h0, BUSY}, 32'h1);
      check({tag, "_novalid"}, {31'h0, VALID}, 32'h0);
      @(negedge CLK);
    end
    check({tag, "_valid"}, {31'h0, VALID}, 32'h1);
    check({tag, "_busy_low"}, {31'h0, BUSY}, 32'h0);
    check_result(tag);
  endtask

  task automatic do_conv(input string tag, input logic [31:0] data, input logic uns,
                         input logic [2:0] mode, input logic [31:0] res, input logic nx);
    exp_q.push_back({nx, res});
    start_conv(data, uns, mode, 1'b0);
    expect_window(tag);
  endtask

  initial begin
    bit saw_valid;

    // Reset.
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", {31'h0, BUSY}, 32'h0);
    check("rst_valid", {31'h0, VALID}, 32'h0);
    check("rst_result", RESULT, 32'h0);
    check("rst_inexact", {31'h0, INEXACT}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    RESET = 1'b1;

    // Basic vectors.
    do_conv("one",       32'h0000_0001, 1'b0, M_RNE, 32'h3F80_0000, 1'b0);
    do_conv("neg_one",   32'hFFFF_FFFF, 1'b0, M_RNE, 32'hBF80_0000, 1'b0);
    do_conv("umax",      32'hFFFF_FFFF, 1'b1, M_RNE, 32'h4F80_0000, 1'b1);
    do_conv("int_min",   32'h8000_0000, 1'b0, M_RNE, 32'hCF00_0000, 1'b0);
    do_conv("tie_rne",   32'h0100_0001, 1'b0, M_RNE, 32'h4B80_0000, 1'b1);
    do_conv("rup",       32'h0100_0001, 1'b0, M_RUP, 32'h4B80_0001, 1'b1);
    do_conv("rtz",       32'h0100_0001, 1'b0, M_RTZ, 32'h4B80_0000, 1'b1);
    do_conv("rdn_neg",   32'hFEFF_FFFF, 1'b0, M_RDN, 32'hCB80_0001, 1'b1);
    do_conv("rmm",       32'h0100_0001, 1'b0, M_RMM, 32'h4B80_0001, 1'b1);
    do_conv("tie_even",  32'h0100_0003, 1'b0, 3'b111, 32'h4B80_0002, 1'b1);

    // Zero, then START held high through DONE for a back-to-back conversion.
    exp_q.push_back({1'b0, 32'h0000_0000});
    start_conv(32'h0, 1'b0, M_RUP, 1'b1);
    expect_window("zero");
    DATA1 = 32'd5;
    UNSIGNED = 1'b0;
    ROUND_MODE = M_RNE;
    exp_q.push_back({1'b0, 32'h40A0_0000});
    @(negedge CLK);
    START = 1'b0;
    DATA1 = $urandom;
    expect_window("b2b");

    // START while BUSY is ignored.
    exp_q.push_back({1'b0, 32'h4000_0000});
    start_conv(32'd2, 1'b0, M_RNE, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) begin
        START = 1'b1;
        DATA1 = 32'hFFFF_FFFF;
        UNSIGNED = 1'b1;
      end
      if (c == 4) START = 1'b0;
      check("ign_busy", {31'h0, BUSY}, 32'h1);
      @(negedge CLK);
    end
    check("ign_valid", {31'h0, VALID}, 32'h1);
    check_result("ign");
    @(negedge CLK);
    check("ign_no_second", {31'h0, VALID}, 32'h0);
    check("ign_idle", {30'h0, dbg_state}, 32'h0);

    // Reset mid-conversion clears outputs immediately and drops the result.
    start_conv(32'd3, 1'b0, M_RNE, 1'b0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("midrst_busy", {31'h0, BUSY}, 32'h0);
    check("midrst_valid", {31'h0, VALID}, 32'h0);
    check("midrst_result", RESULT, 32'h0);
    check("midrst_inexact", {31'h0, INEXACT}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (VALID) saw_valid = 1'b1;
    end
    check("midrst_no_valid", {31'h0, saw_valid}, 32'h0);
    do_conv("after_rst", 32'd7, 1'b0, M_RNE, 32'h40E0_0000, 1'b0);

    check("sb_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
